// File: rtl/nv_mem_reader.sv
// nv_mem_reader: fetches a contiguous run of words from nv_memory and streams them out
// through a 2-entry buffer with valid/ready backpressure.
module nv_mem_reader #(
    parameter int AW = 8,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   word_count,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_w,
    output logic [AW-1:0] mem_addr_out,
    output logic [DW-1:0] mem_data_out,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;
    state_t        state;
    logic [AW:0]   left;
    logic          infl;
    logic [1:0]    cnt;
    logic [1:0]    occ;
    logic [DW-1:0] b0, b1;
    logic          pop, issue;
    assign mem_w        = 1'b0;
    assign mem_data_out = '0;
    assign out_valid    = cnt != 2'd0;
    assign out_data     = b0;
    assign pop          = out_valid & out_ready;
    // occupancy after this edge's pop and landing read, before any new issue
    assign occ          = cnt - 2'(pop) + 2'(infl);
    assign issue        = state == FETCH && left != '0 && occ < 2'd2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            left         <= '0;
            infl         <= 1'b0;
            cnt          <= 2'd0;
            b0           <= '0;
            b1           <= '0;
            mem_addr_out <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            infl <= issue;
            cnt  <= occ;
            err  <= 1'b0;
            done <= 1'b0;
            if (pop)
                b0 <= b1;
            if (infl) begin
                if (cnt == {1'b0, pop})
                    b0 <= mem_rdata;
                else
                    b1 <= mem_rdata;
            end
            if (issue) begin
                mem_addr_out <= mem_addr_out + AW'(1);
                left         <= left - (AW+1)'(1);
            end
            case (state)
                IDLE: begin
                    if (start && word_count == '0)
                        err <= 1'b1;
                    else if (start) begin
                        mem_addr_out <= base_addr;
                        left         <= word_count;
                        busy         <= 1'b1;
                        state        <= FETCH;
                    end
                end
                FETCH: if (issue && left == (AW+1)'(1)) state <= DRAIN;
                DRAIN: begin
                    if (occ == 2'd0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/nv_mem_reader.md
Name: nv_mem_reader

Overview:
- Read-side master for nv_memory. On `start`, it fetches a contiguous run of 64-bit words from the non-volatile store, starting at a given address.
- Fetched words are delivered on a valid/ready stream to downstream consumers (key loader, bitstream decryptor).
- It drives the memory's write-enable/address/data inputs and consumes the memory's `mem_data_out`. It applies backpressure through a 2-entry output buffer.

Parameters:
- AW, 8, memory address width; depth is 2**AW words.
- DW, 64, memory/stream data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; single clock `clk`; all state clears immediately on assertion.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  AW  first word address, captured on accepted start.
- word_count  in  AW+1  number of words to read, 1..2**AW; captured on accepted start.
- busy  out  1  high from accepted start until done pulse (inclusive).
- done  out  1  one-cycle pulse after last word handshaked.
- err  out  1  one-cycle pulse when start arrives with word_count==0.
- mem_w  out  1  memory write enable; constant 0 (reader never writes).
- mem_addr_out  out  AW  memory address.
- mem_data_out  out  DW  memory write data; constant 0.
- mem_rdata  in  DW  memory read data. Valid one clk after mem_addr_out is presented (registered read, latency 1).
- out_data  out  DW  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; transfer when out_valid & out_ready at rising edge.

Behaviour:
- Reset values:
  - busy, done, err, out_valid, mem_w = 0.
  - mem_addr_out, mem_data_out, out_data = 0.
  - Buffer empty; counters 0; state IDLE.
- States: IDLE, FETCH, DRAIN, FIN.
- IDLE:
  - start & word_count!=0 → capture base_addr/word_count, busy=1, go FETCH.
  - start & word_count==0 → err pulse next cycle, stay IDLE, busy stays 0.
- FETCH, issue rule:
  - A read is issued in a cycle iff (buffer occupancy + reads in flight) < 2 and issued < word_count.
  - Issuing means mem_addr_out = current address; that address's data is written into the buffer on the next edge.
  - At most 1 read in flight (latency 1).
- FETCH, addressing and exit:
  - Address increments modulo 2**AW after each issue. Wrap 255→0 is legal and silent.
  - When issued == word_count → DRAIN.
- DRAIN: wait until the last in-flight read lands and the buffer empties through handshakes → FIN.
- FIN: done=1 for exactly one cycle; busy=0 the following cycle; → IDLE. A start in the FIN cycle is ignored.
- Buffer:
  - 2-entry FIFO; out_valid = not empty; out_data = head entry.
  - Simultaneous push and pop permitted; occupancy unchanged.
  - Never overflows, guaranteed by the issue rule. Words leave in address order; none dropped or duplicated.
- Throughput and latency:
  - With out_ready held 1, one word per cycle is sustained after the first.
  - First out_valid rises 2 cycles after the accepted start edge: capture, issue, land.
  - If out_ready is held 0, fetching stalls with 2 words buffered; mem_addr_out holds its last value.
- busy=1 in FETCH, DRAIN and FIN. start while busy is ignored, with no err.
- mem_w=0 at all times, including reset and mid-run.
- Reset mid-operation: all state and buffer cleared asynchronously. Partial data is discarded; no done pulse. After release the block is in IDLE and accepts a new start.
- word_count = 2**AW (256) reads the whole memory, starting at base_addr and wrapping.

Test Plan:
1. Preload memory (mem_w=1) with addr0=256, addr1=555, addr200=2560. Start base=0 count=2, out_ready=1 → out_data sequence 256 then 555 on consecutive valid cycles; done one cycle after second handshake; mem_w never 1 from reader.
2. Start base=200 count=1 → single word 2560, then done; busy high for exactly capture+issue+land+handshake+FIN cycles.
3. Backpressure: count=4, out_ready=0 for 10 cycles after start → out_valid=1, 2 words buffered, address stops advancing. Then out_ready toggling 1/0 → all 4 words in order, no duplicates.
4. Wrap: base=255 count=3 with addr255=0xAA, addr0=256, addr1=555 → outputs 0xAA, 256, 555; no err.
5. Errors and ignores: start with count=0 → err pulse, busy stays 0. Start during busy → ignored, run completes normally.
6. Reset: rst_n low mid-run after 1 of 4 words → out_valid/busy drop immediately, no done. Post-release start base=1 count=1 → 555.
